// File: rtl/auxpll_lf_if.sv
// auxpll_lf_if: control, gain and status signals between the PLL controller and the loop filter
interface auxpll_lf_if #(
  parameter int DW = 10
);
  logic          EN;
  logic          PD;
  logic [3:0]    KP_ACQ;
  logic [3:0]    KI_ACQ;
  logic [3:0]    KP_TRK;
  logic [3:0]    KI_TRK;
  logic [DW-1:0] DCW;
  logic          LOCK;
  logic [1:0]    STATE;
  modport master (output EN, PD, KP_ACQ, KI_ACQ, KP_TRK, KI_TRK, input DCW, LOCK, STATE);
  modport slave  (input EN, PD, KP_ACQ, KI_ACQ, KP_TRK, KI_TRK, output DCW, LOCK, STATE);
endinterface

// File: rtl/auxpll_lf.sv
// auxpll_lf: bang-bang PI loop filter with ACQ/TRACK gear shift and toggle-density lock detector
module auxpll_lf #(
  parameter int DW       = 10,
  parameter int FRAC     = 8,
  parameter int DCW_INIT = 512,
  parameter int ACQ_CYC  = 256,
  parameter int LOCK_WIN = 64,
  parameter int LOCK_TH  = 24
) (
  input logic        CK250M,
  input logic        NRST,
  auxpll_lf_if.slave lf
);
  localparam int IW = DW + FRAC;
  localparam int PW = $clog2(ACQ_CYC);
  localparam int WW = $clog2(LOCK_WIN);
  localparam int TW = $clog2(LOCK_WIN + 1);
  typedef enum logic [1:0] {IDLE, ACQ, TRACK, LOCKED} state_t;
  state_t                 state_q;
  logic [DW-1:0]          dcw_q, dcw_d;
  logic [IW-1:0]          int_q, int_d;
  logic                   lock_q, pd_prev_q;
  logic [PW-1:0]          ph_q;
  logic [WW-1:0]          win_q;
  logic [TW-1:0]          tog_q, tog_d;
  logic [3:0]             kp, ki;
  int                     kp_e, ki_e;
  logic [IW+1:0]          kp_step, ki_step, int_sum;
  logic signed [IW+1:0]   dcw_sum, dcw_sh;
  logic                   win_end, lock_d;
  always_comb begin
    kp      = (state_q == ACQ) ? lf.KP_ACQ : lf.KP_TRK;
    ki      = (state_q == ACQ) ? lf.KI_ACQ : lf.KI_TRK;
    kp_e    = (int'(kp) >= IW) ? IW - 1 : int'(kp);
    ki_e    = (int'(ki) >= IW) ? IW - 1 : int'(ki);
    kp_step = (IW+2)'(1) << kp_e;
    ki_step = (IW+2)'(1) << ki_e;
    int_sum = lf.PD ? {2'b00, int_q} + ki_step : {2'b00, int_q} - ki_step;
    // overflow shows up in bit IW, underflow wraps into the sign bit IW+1
    int_d   = lf.PD ? (int_sum[IW] ? '1 : int_sum[IW-1:0])
                    : (int_sum[IW+1] ? '0 : int_sum[IW-1:0]);
    dcw_sum = lf.PD ? signed'({2'b00, int_d} + kp_step) : signed'({2'b00, int_d} - kp_step);
    dcw_sh  = dcw_sum >>> FRAC;
    dcw_d   = dcw_sh[IW+1] ? '0 : (|dcw_sh[IW:DW] ? '1 : dcw_sh[DW-1:0]);
    tog_d   = (tog_q == TW'(LOCK_WIN)) ? tog_q : tog_q + TW'(lf.PD != pd_prev_q);
    win_end = win_q == WW'(LOCK_WIN - 1);
    lock_d  = tog_d >= TW'(LOCK_TH);
  end
  always_ff @(posedge CK250M) begin
    if (!NRST || !lf.EN) begin
      state_q   <= IDLE;
      dcw_q     <= DW'(DCW_INIT);
      int_q     <= IW'(DCW_INIT) << FRAC;
      lock_q    <= 1'b0;
      pd_prev_q <= 1'b0;
      ph_q      <= '0;
      win_q     <= '0;
      tog_q     <= '0;
    end else if (state_q == IDLE) begin
      state_q <= ACQ;
    end else begin
      int_q     <= int_d;
      dcw_q     <= dcw_d;
      pd_prev_q <= lf.PD;
      if (state_q == ACQ) begin
        ph_q <= ph_q + 1'b1;
        if (ph_q == PW'(ACQ_CYC - 1)) begin
          state_q   <= TRACK;
          ph_q      <= '0;
          pd_prev_q <= 1'b0;
          win_q     <= '0;
          tog_q     <= '0;
        end
      end else if (win_end) begin
        win_q   <= '0;
        tog_q   <= '0;
        state_q <= lock_d ? LOCKED : TRACK;
        lock_q  <= lock_d;
      end else begin
        win_q <= win_q + 1'b1;
        tog_q <= tog_d;
      end
    end
  end
  assign lf.DCW   = dcw_q;
  assign lf.LOCK  = lock_q;
  assign lf.STATE = state_q;
endmodule

// File: tb/tb_auxpll_lf.sv
// tb_auxpll_lf: directed vector table plus multi-cycle gear-shift, lock, unlock, disable and saturation sequences
module tb_auxpll_lf;
  logic clk = 1'b0;
  logic nrst;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  auxpll_lf_if #(.DW(10)) s1 ();
  auxpll_lf_if #(.DW(10)) s2 ();
  auxpll_lf_if #(.DW(10)) s3 ();
  auxpll_lf #(.DCW_INIT(512))  u1 (.CK250M(clk), .NRST(nrst), .lf(s1.slave));
  auxpll_lf #(.DCW_INIT(1020)) u2 (.CK250M(clk), .NRST(nrst), .lf(s2.slave));
  auxpll_lf #(.DCW_INIT(0))    u3 (.CK250M(clk), .NRST(nrst), .lf(s3.slave));
  assign s3.EN     = s2.EN;
  assign s3.PD     = s2.PD;
  assign s3.KP_ACQ = s2.KP_ACQ;
  assign s3.KI_ACQ = s2.KI_ACQ;
  assign s3.KP_TRK = s2.KP_TRK;
  assign s3.KI_TRK = s2.KI_TRK;
  typedef struct {
    logic       en;
    logic       pd;
    logic [3:0] kp;
    logic [3:0] ki;
    int         dcw;
    int         st;
    int         lk;
  } vec_t;
  vec_t tv[19];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input int dcw, input int st, input int lk);
    chk({name, ".dcw"}, int'(s1.DCW), dcw);
    chk({name, ".state"}, int'(s1.STATE), st);
    chk({name, ".lock"}, int'(s1.LOCK), lk);
  endtask
  initial begin
    tv[0]  = '{1'b1, 1'b1, 4'd0, 4'd8, 512, 1, 0};
    tv[1]  = '{1'b1, 1'b1, 4'd0, 4'd8, 513, 1, 0};
    tv[2]  = '{1'b1, 1'b1, 4'd0, 4'd8, 514, 1, 0};
    tv[3]  = '{1'b1, 1'b1, 4'd0, 4'd8, 515, 1, 0};
    tv[4]  = '{1'b1, 1'b1, 4'd0, 4'd8, 516, 1, 0};
    tv[5]  = '{1'b1, 1'b1, 4'd0, 4'd8, 517, 1, 0};
    tv[6]  = '{1'b1, 1'b1, 4'd0, 4'd8, 518, 1, 0};
    tv[7]  = '{1'b1, 1'b1, 4'd0, 4'd8, 519, 1, 0};
    tv[8]  = '{1'b1, 1'b1, 4'd0, 4'd8, 520, 1, 0};
    tv[9]  = '{1'b1, 1'b1, 4'd0, 4'd8, 521, 1, 0};
    tv[10] = '{1'b1, 1'b1, 4'd0, 4'd8, 522, 1, 0};
    tv[11] = '{1'b1, 1'b0, 4'd0, 4'd8, 520, 1, 0};
    tv[12] = '{1'b1, 1'b0, 4'd8, 4'd0, 519, 1, 0};
    tv[13] = '{1'b1, 1'b1, 4'd8, 4'd0, 522, 1, 0};
    tv[14] = '{1'b1, 1'b1, 4'd9, 4'd4, 523, 1, 0};
    tv[15] = '{1'b1, 1'b0, 4'd9, 4'd4, 519, 1, 0};
    tv[16] = '{1'b0, 1'b1, 4'd9, 4'd4, 512, 0, 0};
    tv[17] = '{1'b1, 1'b1, 4'd0, 4'd8, 512, 1, 0};
    tv[18] = '{1'b1, 1'b1, 4'd0, 4'd8, 513, 1, 0};
    nrst = 1'b0;
    s1.EN = 1'b1; s1.PD = 1'b1; s1.KP_ACQ = 4'd0; s1.KI_ACQ = 4'd8; s1.KP_TRK = 4'd8; s1.KI_TRK = 4'd4;
    s2.EN = 1'b1; s2.PD = 1'b1; s2.KP_ACQ = 4'd0; s2.KI_ACQ = 4'd8; s2.KP_TRK = 4'd0; s2.KI_TRK = 4'd0;
    repeat (3) tick();
    chk1("reset", 512, 0, 0);
    s2.EN = 1'b0;
    nrst = 1'b1;
    for (int i = 0; i < 19; i++) begin
      s1.EN = tv[i].en; s1.PD = tv[i].pd; s1.KP_ACQ = tv[i].kp; s1.KI_ACQ = tv[i].ki;
      tick();
      chk1($sformatf("vec%0d", i), tv[i].dcw, tv[i].st, tv[i].lk);
    end
    s1.EN = 1'b0;
    tick();
    chk1("idle", 512, 0, 0);
    s1.EN = 1'b1; s1.PD = 1'b0; s1.KP_ACQ = 4'd0; s1.KI_ACQ = 4'd8;
    tick();
    for (int u = 1; u <= 256; u++) begin
      s1.PD = u[0];
      tick();
      if (u == 255) chk1("acq_last", 513, 1, 0);
      if (u == 256) chk1("to_track", 511, 2, 0);
    end
    for (int t = 1; t <= 64; t++) begin
      s1.PD = t[0];
      tick();
      if (t == 1) chk1("trk_dither_hi", 513, 2, 0);
      if (t == 2) chk1("trk_dither_lo", 511, 2, 0);
      if (t == 63) chk1("pre_lock", 513, 2, 0);
      if (t == 64) chk1("locked", 511, 3, 1);
    end
    for (int j = 0; j < 64; j++) begin
      s1.PD = 1'b1;
      tick();
      if (j == 62) chk1("pre_unlock", 516, 3, 1);
      if (j == 63) chk1("unlocked", 517, 2, 0);
    end
    for (int k = 0; k < 64; k++) begin
      s1.PD = k[0];
      tick();
    end
    chk1("relocked", int'(s1.DCW), 3, 1);
    s1.EN = 1'b0;
    tick();
    chk1("disable", 512, 0, 0);
    s1.EN = 1'b1; s1.PD = 1'b1;
    tick();
    chk1("restart", 512, 1, 0);
    for (int u = 1; u <= 256; u++) begin
      tick();
      if (u == 1) chk1("restart_upd", 513, 1, 0);
      if (u == 255) chk1("restart_acq_last", 767, 1, 0);
      if (u == 256) chk1("restart_track", 768, 2, 0);
    end
    s2.EN = 1'b1; s2.PD = 1'b0;
    tick();
    chk("sat_enter", int'(s2.STATE), 1);
    tick();
    chk("sat_hi_dn", int'(s2.DCW), 1018);
    chk("sat_lo_zero", int'(s3.DCW), 0);
    s2.PD = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) chk("sat_lo_nowrap", int'(s3.DCW), 1);
      if (i == 4) chk("sat_hi_reach", int'(s2.DCW), 1023);
      if (i == 5) chk("sat_hi_clamp", int'(s2.DCW), 1023);
    end
    chk("sat_hi_pinned", int'(s2.DCW), 1023);
    chk("sat_lo_ramp", int'(s3.DCW), 20);
    s2.PD = 1'b0;
    tick();
    chk("sat_hi_release", int'(s2.DCW), 1022);
    chk("sat_lo_down", int'(s3.DCW), 18);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
